// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : RAM access sequencer that sits directly upstream of the MDR.
//               It accepts single read/write requests from the control unit
//               and latches the address and write data. It runs the sequence
//               SETUP -> ACCESS (wait states) -> FINISH. On a read it captures
//               the RAM word and pulses mdr_en so the MDR loads it.
//               Optional feature macro: MEM_READY_EN. When it is defined, the
//               ram_ready port exists and ACCESS stretches until the RAM is
//               ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int MAX_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,       // asynchronous, active-low
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [MAX_WIDTH-1:0]  wdata,
    input  logic [MAX_WIDTH-1:0]  ram_din,
`ifdef MEM_READY_EN
    input  logic                  ram_ready,
`endif
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [MAX_WIDTH-1:0]  ram_dout,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [MAX_WIDTH-1:0]  rdata,
    output logic                  mdr_en,
    output logic                  busy,
    output logic                  done
);

    // Counter must be at least one bit wide, even with zero wait states
    localparam int                CNT_W    = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   op_wr_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [MAX_WIDTH-1:0]   dout_q;
    logic [MAX_WIDTH-1:0]   rdata_q;
    logic                   ce_q;
    logic                   we_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   mdr_en_q;

    logic                   ready_w;
    logic                   access_exit_w;

`ifdef MEM_READY_EN
    assign ready_w = ram_ready;
`else
    assign ready_w = 1'b1;
`endif

    // ACCESS ends once the wait-state budget is spent and the RAM is ready
    assign access_exit_w = (cnt_q == CNT_LAST) && ready_w;

    // Single-process FSM. Every output is a register, so the outputs stay glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mdr_en_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_wr || req_rd) begin
                        // A write wins when both requests are high; the read is dropped
                        addr_q  <= addr_in;
                        dout_q  <= wdata;
                        op_wr_q <= req_wr;
                        ce_q    <= 1'b1;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt_q   <= '0;
                    we_q    <= op_wr_q;
                    state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (access_exit_w) begin
                        we_q     <= 1'b0;
                        done_q   <= 1'b1;
                        mdr_en_q <= ~op_wr_q;
                        if (!op_wr_q) begin
                            rdata_q <= ram_din;
                        end
                        state_q  <= S_FINISH;
                    end else if (cnt_q != CNT_LAST) begin
                        // Saturate at the last count while waiting for ready
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_FINISH: begin
                    ce_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    mdr_en_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    ce_q     <= 1'b0;
                    we_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    mdr_en_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr = addr_q;
    assign ram_dout = dout_q;
    assign ram_ce   = ce_q;
    assign ram_we   = we_q;
    assign rdata    = rdata_q;
    assign mdr_en   = mdr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. It uses a vector
//               table, per-cycle strobe profiles and a completion scoreboard.
//               A second instance is built with zero wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int TB_WS = 2;

    logic       clk;
    logic       rst;
    logic       req_rd, req_wr;
    logic [7:0] addr_in, wdata, ram_din;
    logic       ram_ready;
    logic [7:0] ram_addr, ram_dout, rdata;
    logic       ram_ce, ram_we, mdr_en, busy, done;

    // Zero-wait-state instance
    logic       r0_rd;
    logic [7:0] r0_addr, r0_din;
    logic [7:0] w0_addr, w0_dout, w0_rdata;
    logic       w0_ce, w0_we, w0_mdr, w0_busy, w0_done;

    mem_access_ctrl #(.MAX_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(TB_WS)) u_dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .addr_in(addr_in), .wdata(wdata), .ram_din(ram_din),
`ifdef MEM_READY_EN
        .ram_ready(ram_ready),
`endif
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_ce(ram_ce), .ram_we(ram_we),
        .rdata(rdata), .mdr_en(mdr_en), .busy(busy), .done(done)
    );

    mem_access_ctrl #(.MAX_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_rd(r0_rd), .req_wr(1'b0),
        .addr_in(r0_addr), .wdata(8'h00), .ram_din(r0_din),
`ifdef MEM_READY_EN
        .ram_ready(ram_ready),
`endif
        .ram_addr(w0_addr), .ram_dout(w0_dout), .ram_ce(w0_ce), .ram_we(w0_we),
        .rdata(w0_rdata), .mdr_en(w0_mdr), .busy(w0_busy), .done(w0_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        int         pulse_k;   // cycle in which a stray req_rd is pulsed, -1 for none
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] dout;
        logic [7:0] rdata;
        logic       mdr;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_done   = 0;
    int         n_pushed = 0;
    logic [7:0] model_rdata = 8'h00;
    vec_t       tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_addr",  {24'd0, ram_addr}, {24'd0, e.addr});
                chk("sb_dout",  {24'd0, ram_dout}, {24'd0, e.dout});
                chk("sb_rdata", {24'd0, rdata},    {24'd0, e.rdata});
                chk("sb_mdr",   {31'd0, mdr_en},   {31'd0, e.mdr});
            end
        end
    end

    // One request, observed over 8 cycles (k=0 is the request cycle)
    task automatic run_txn(input vec_t v);
        logic [7:0] ce_v, we_v, done_v, mdr_v, busy_v;
        logic [7:0] ce_e, we_e, done_e, mdr_e;
        logic       is_wr, is_rd;
        exp_t       e;
        is_wr = v.wr;
        is_rd = v.rd & ~v.wr;
        ce_v = '0; we_v = '0; done_v = '0; mdr_v = '0; busy_v = '0;
        ce_e = '0; we_e = '0; done_e = '0; mdr_e = '0;
        for (int k = 0; k < 8; k++) begin
            ce_e[k]   = (k >= 1) && (k <= TB_WS + 3);
            we_e[k]   = is_wr && (k >= 2) && (k <= TB_WS + 2);
            done_e[k] = (k == TB_WS + 3);
            mdr_e[k]  = is_rd && (k == TB_WS + 3);
        end
        @(negedge clk);
        ce_v[0] = ram_ce; we_v[0] = ram_we; done_v[0] = done; mdr_v[0] = mdr_en; busy_v[0] = busy;
        req_rd  = v.rd;
        req_wr  = v.wr;
        addr_in = v.addr;
        wdata   = v.wdata;
        ram_din = v.din;
        if (is_rd) model_rdata = v.din;
        e.addr  = v.addr;
        e.dout  = v.wdata;
        e.rdata = model_rdata;
        e.mdr   = is_rd;
        sb_q.push_back(e);
        n_pushed++;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            ce_v[k] = ram_ce; we_v[k] = ram_we; done_v[k] = done; mdr_v[k] = mdr_en; busy_v[k] = busy;
            req_wr  = 1'b0;
            req_rd  = (k == v.pulse_k);
            addr_in = ~v.addr;
            wdata   = ~v.wdata;
            if (k >= TB_WS + 3) ram_din = ~v.din;
        end
        req_rd = 1'b0;
        chk("ce_profile",   {24'd0, ce_v},   {24'd0, ce_e});
        chk("we_profile",   {24'd0, we_v},   {24'd0, we_e});
        chk("done_profile", {24'd0, done_v}, {24'd0, done_e});
        chk("mdr_profile",  {24'd0, mdr_v},  {24'd0, mdr_e});
        chk("busy_profile", {24'd0, busy_v}, {24'd0, ce_e});
        chk("rdata_hold",   {24'd0, rdata},  {24'd0, model_rdata});
        chk("addr_hold",    {24'd0, ram_addr}, {24'd0, v.addr});
        chk("dout_hold",    {24'd0, ram_dout}, {24'd0, v.wdata});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ce0_v, done0_v, mdr0_v, we0_v;
        tbl[0] = '{rd: 1'b1, wr: 1'b0, addr: 8'h3C, wdata: 8'h00, din: 8'hA5, pulse_k: -1};
        tbl[1] = '{rd: 1'b0, wr: 1'b1, addr: 8'h10, wdata: 8'h5A, din: 8'h77, pulse_k: -1};
        tbl[2] = '{rd: 1'b1, wr: 1'b1, addr: 8'h77, wdata: 8'hC3, din: 8'h11, pulse_k: -1};
        tbl[3] = '{rd: 1'b0, wr: 1'b1, addr: 8'h22, wdata: 8'h99, din: 8'h44, pulse_k: 2};
        tbl[4] = '{rd: 1'b1, wr: 1'b0, addr: 8'h00, wdata: 8'h12, din: 8'hFF, pulse_k: -1};
        tbl[5] = '{rd: 1'b0, wr: 1'b1, addr: 8'hFF, wdata: 8'h00, din: 8'h5E, pulse_k: 5};
        tbl[6] = '{rd: 1'b1, wr: 1'b0, addr: 8'h81, wdata: 8'hEE, din: 8'h3C, pulse_k: -1};

        rst = 1'b0; req_rd = 1'b0; req_wr = 1'b0; addr_in = '0; wdata = '0; ram_din = '0;
        ram_ready = 1'b1; r0_rd = 1'b0; r0_addr = '0; r0_din = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {8'd0, ram_addr, ram_dout, rdata},  32'd0);
        chk("reset_strobes", {27'd0, ram_ce, ram_we, mdr_en, busy, done}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Zero wait states: done in cycle 3
        ce0_v = '0; done0_v = '0; mdr0_v = '0; we0_v = '0;
        @(negedge clk);
        r0_rd = 1'b1; r0_addr = 8'h6B; r0_din = 8'h96;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            ce0_v[k] = w0_ce; done0_v[k] = w0_done; mdr0_v[k] = w0_mdr; we0_v[k] = w0_we;
            r0_rd = 1'b0;
        end
        chk("ws0_ce",    {24'd0, ce0_v},   32'h0E);
        chk("ws0_done",  {24'd0, done0_v}, 32'h08);
        chk("ws0_mdr",   {24'd0, mdr0_v},  32'h08);
        chk("ws0_we",    {24'd0, we0_v},   32'h00);
        chk("ws0_rdata", {24'd0, w0_rdata}, 32'h96);
        chk("ws0_addr",  {24'd0, w0_addr},  32'h6B);

        // Asynchronous reset during a write ACCESS
        @(negedge clk);
        req_wr = 1'b1; addr_in = 8'h44; wdata = 8'h11;
        @(negedge clk);
        req_wr = 1'b0;
        @(negedge clk);
        chk("abort_we_before", {31'd0, ram_we}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_strobes", {28'd0, ram_ce, ram_we, busy, done}, 32'd0);
        chk("abort_rdata",   {24'd0, rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_rdata = 8'h00;
        repeat (6) @(negedge clk);
        chk("abort_idle", {30'd0, busy, ram_ce}, 32'd0);
        run_txn('{rd: 1'b1, wr: 1'b0, addr: 8'h5D, wdata: 8'h00, din: 8'hC7, pulse_k: -1});

        chk("done_count",   n_done, n_pushed);
        chk("sb_empty",     sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
